// File: rtl/sdram_arbiter.sv
// Purpose: shares the byte-wide SDRAM port between download, video fetch and CPU; VIDEO_PRIO_EN gives video strict priority over CPU.
// Latency: grant at E0, strobes held SLOT_CYCLES cycles, dout and ack at E0+SLOT_CYCLES, next grant no earlier than E0+SLOT_CYCLES+2.
// Backpressure: level requests are held until the one-cycle ack; non-eligible requests are ignored, not queued.
module sdram_arbiter #(
  parameter int AW          = 25,
  parameter int SLOT_CYCLES = 2
) (
  input  logic          F14M,
  input  logic          RESET_n,
  input  logic          dl_active,
  input  logic          dl_req,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_din,
  output logic          dl_ack,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [7:0]    vid_dout,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic          cpu_ack,
  output logic [7:0]    cpu_dout,
  output logic [AW-1:0] sd_addr,
  output logic [7:0]    sd_din,
  output logic          sd_we,
  output logic          sd_oe,
  input  logic [7:0]    sd_dout,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {OWN_DL, OWN_VID, OWN_CPU} owner_t;

  localparam logic [3:0] SLOT_LAST = 4'(SLOT_CYCLES - 1);

  state_t     state;
  owner_t     owner;
  logic [3:0] slot_cnt;
  logic       grant_dl;
  logic       grant_vid;
  logic       grant_cpu;

`ifndef VIDEO_PRIO_EN
  logic       rr_cpu_last;
`endif

  always_comb begin
    grant_dl  = 1'b0;
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    if (dl_active) begin
      grant_dl = dl_req;
    end else begin
`ifdef VIDEO_PRIO_EN
      if (vid_req)      grant_vid = 1'b1;
      else if (cpu_req) grant_cpu = 1'b1;
`else
      // On a tie the requester that was not served last wins
      if (vid_req && cpu_req) begin
        grant_vid = rr_cpu_last;
        grant_cpu = !rr_cpu_last;
      end else begin
        grant_vid = vid_req;
        grant_cpu = cpu_req;
      end
`endif
    end
  end

`ifndef VIDEO_PRIO_EN
  always_ff @(posedge F14M or negedge RESET_n) begin
    if (!RESET_n) begin
      rr_cpu_last <= 1'b1;
    end else if (state == IDLE) begin
      if (grant_vid)      rr_cpu_last <= 1'b0;
      else if (grant_cpu) rr_cpu_last <= 1'b1;
    end
  end
`endif

  always_ff @(posedge F14M or negedge RESET_n) begin
    if (!RESET_n) begin
      state    <= IDLE;
      owner    <= OWN_DL;
      slot_cnt <= '0;
      sd_addr  <= '0;
      sd_din   <= '0;
      sd_we    <= 1'b0;
      sd_oe    <= 1'b0;
      busy     <= 1'b0;
      dl_ack   <= 1'b0;
      vid_ack  <= 1'b0;
      cpu_ack  <= 1'b0;
      vid_dout <= '0;
      cpu_dout <= '0;
    end else begin
      dl_ack  <= 1'b0;
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          slot_cnt <= '0;
          if (grant_dl || grant_vid || grant_cpu) begin
            state <= ACCESS;
            busy  <= 1'b1;
          end
          if (grant_dl) begin
            owner   <= OWN_DL;
            sd_addr <= dl_addr;
            sd_din  <= dl_din;
            sd_we   <= 1'b1;
          end else if (grant_vid) begin
            owner   <= OWN_VID;
            sd_addr <= vid_addr;
            sd_oe   <= 1'b1;
          end else if (grant_cpu) begin
            owner   <= OWN_CPU;
            sd_addr <= cpu_addr;
            if (cpu_we) sd_din <= cpu_din;
            sd_we   <= cpu_we;
            sd_oe   <= !cpu_we;
          end
        end
        ACCESS: begin
          if (slot_cnt == SLOT_LAST) begin
            sd_we <= 1'b0;
            sd_oe <= 1'b0;
            state <= DONE;
            // sd_oe still high here marks the access as a read
            case (owner)
              OWN_DL:  dl_ack <= 1'b1;
              OWN_VID: begin
                vid_ack <= 1'b1;
                if (sd_oe) vid_dout <= sd_dout;
              end
              OWN_CPU: begin
                cpu_ack <= 1'b1;
                if (sd_oe) cpu_dout <= sd_dout;
              end
              default: ;
            endcase
          end else begin
            slot_cnt <= slot_cnt + 4'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: default-slot instance plus a SLOT_CYCLES=5 instance.
module tb_sdram_arbiter;
  localparam int AW = 25;

  logic F14M = 1'b0;
  always #5 F14M = ~F14M;

  logic          RESET_n;
  logic          dl_active, dl_req, vid_req, cpu_req, cpu_we;
  logic [AW-1:0] dl_addr, vid_addr, cpu_addr;
  logic [7:0]    dl_din, cpu_din;
  logic          dl_ack, vid_ack, cpu_ack, sd_we, sd_oe, busy;
  logic [7:0]    vid_dout, cpu_dout, sd_din, sd_dout;
  logic [AW-1:0] sd_addr;

  logic          vid_req5;
  logic [AW-1:0] vid_addr5;
  logic          dl_ack5, vid_ack5, cpu_ack5, sd_we5, sd_oe5, busy5;
  logic [7:0]    vid_dout5, cpu_dout5, sd_din5, sd_dout5;
  logic [AW-1:0] sd_addr5;

  // SDRAM read model: data is a fixed function of the address
  function automatic logic [7:0] mem(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  assign sd_dout  = mem(sd_addr);
  assign sd_dout5 = mem(sd_addr5);

  sdram_arbiter #(.AW(AW), .SLOT_CYCLES(2)) u_dut (
    .F14M(F14M), .RESET_n(RESET_n), .dl_active(dl_active), .dl_req(dl_req),
    .dl_addr(dl_addr), .dl_din(dl_din), .dl_ack(dl_ack), .vid_req(vid_req),
    .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_dout(vid_dout), .cpu_req(cpu_req),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_ack(cpu_ack),
    .cpu_dout(cpu_dout), .sd_addr(sd_addr), .sd_din(sd_din), .sd_we(sd_we),
    .sd_oe(sd_oe), .sd_dout(sd_dout), .busy(busy)
  );

  sdram_arbiter #(.AW(AW), .SLOT_CYCLES(5)) u_dut5 (
    .F14M(F14M), .RESET_n(RESET_n), .dl_active(1'b0), .dl_req(1'b0),
    .dl_addr({AW{1'b0}}), .dl_din(8'h00), .dl_ack(dl_ack5), .vid_req(vid_req5),
    .vid_addr(vid_addr5), .vid_ack(vid_ack5), .vid_dout(vid_dout5), .cpu_req(1'b0),
    .cpu_we(1'b0), .cpu_addr({AW{1'b0}}), .cpu_din(8'h00), .cpu_ack(cpu_ack5),
    .cpu_dout(cpu_dout5), .sd_addr(sd_addr5), .sd_din(sd_din5), .sd_we(sd_we5),
    .sd_oe(sd_oe5), .sd_dout(sd_dout5), .busy(busy5)
  );

  typedef struct packed {
    logic [1:0] who;   // 0 = dl, 1 = vid, 2 = cpu
    logic [7:0] dat;   // required dout of the owner when acked
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_cpu;

  // Every ack from the main instance must match the next queued expectation
  always @(negedge F14M) begin : mon
    exp_t       e;
    logic [2:0] want;
    if (RESET_n === 1'b1 && (dl_ack || vid_ack || cpu_ack)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected: got acks dl/vid/cpu=%b%b%b, expected none", dl_ack, vid_ack, cpu_ack);
      end else begin
        e = exp_q.pop_front();
        want = (e.who == 2'd0) ? 3'b100 : (e.who == 2'd1) ? 3'b010 : 3'b001;
        if ({dl_ack, vid_ack, cpu_ack} !== want ||
            (e.who == 2'd1 && vid_dout !== e.dat) || (e.who == 2'd2 && cpu_dout !== e.dat)) begin
          errors++;
          $display("FAIL ack_scoreboard: got acks=%b vid_dout=%h cpu_dout=%h, expected acks=%b dout=%h",
                   {dl_ack, vid_ack, cpu_ack}, vid_dout, cpu_dout, want, e.dat);
        end
      end
    end
  end

  task automatic test_reset();
    RESET_n = 1'b0;
    dl_active = 0; dl_req = 0; vid_req = 0; cpu_req = 0; cpu_we = 0; vid_req5 = 0;
    dl_addr = '0; vid_addr = '0; cpu_addr = '0; vid_addr5 = '0; dl_din = 0; cpu_din = 0;
    #12;
    checks++;
    if ({sd_we, sd_oe, busy, dl_ack, vid_ack, cpu_ack} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b, expected 000000", {sd_we, sd_oe, busy, dl_ack, vid_ack, cpu_ack});
    end
    checks++;
    if (sd_addr !== '0 || sd_din !== 8'h00 || vid_dout !== 8'h00 || cpu_dout !== 8'h00) begin
      errors++; $display("FAIL reset_data: got addr=%h din=%h vd=%h cd=%h, expected zeros", sd_addr, sd_din, vid_dout, cpu_dout);
    end
    @(negedge F14M);
    RESET_n = 1'b1;
    m_cpu = 8'h00;
  endtask

  task automatic test_cpu_read();
    int oe_n = 0;
    int ack_at = -1;
    @(negedge F14M);
    cpu_we = 0; cpu_addr = 25'h00_00FF; cpu_req = 1;
    exp_q.push_back(exp_t'{2'd2, 8'hA5});
    m_cpu = 8'hA5;
    for (int c = 0; c < 20 && ack_at < 0; c++) begin
      @(negedge F14M);
      if (c == 0) begin
        checks++;
        if (sd_oe !== 1'b1 || busy !== 1'b1 || sd_addr !== 25'h00_00FF) begin
          errors++; $display("FAIL cpu_rd_grant: got oe=%b busy=%b addr=%h, expected 1 1 000ff", sd_oe, busy, sd_addr);
        end
      end
      if (sd_oe) oe_n++;
      if (cpu_ack) begin
        ack_at = c; cpu_req = 0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL cpu_rd_busy_ack: got %b, expected 1", busy); end
      end
    end
    checks++;
    if (ack_at != 2) begin errors++; $display("FAIL cpu_rd_ack_cycle: got %0d, expected 2", ack_at); end
    checks++;
    if (oe_n != 2) begin errors++; $display("FAIL cpu_rd_oe_len: got %0d, expected 2", oe_n); end
    @(negedge F14M);
    checks++;
    if (busy !== 1'b0 || cpu_ack !== 1'b0) begin
      errors++; $display("FAIL cpu_rd_idle: got busy=%b ack=%b, expected 0 0", busy, cpu_ack);
    end
  endtask

  task automatic test_cpu_write();
    int we_n = 0;
    int oe_n = 0;
    int ack_at = -1;
    @(negedge F14M);
    cpu_we = 1; cpu_addr = 25'h00_1234; cpu_din = 8'h3C; cpu_req = 1;
    exp_q.push_back(exp_t'{2'd2, m_cpu});
    for (int c = 0; c < 20 && ack_at < 0; c++) begin
      @(negedge F14M);
      if (c == 0) begin
        checks++;
        if (sd_addr !== 25'h00_1234 || sd_din !== 8'h3C) begin
          errors++; $display("FAIL cpu_wr_bus: got addr=%h din=%h, expected 0001234 3c", sd_addr, sd_din);
        end
      end
      if (sd_we) we_n++;
      if (sd_oe) oe_n++;
      if (cpu_ack) begin ack_at = c; cpu_req = 0; cpu_we = 0; end
    end
    checks++;
    if (we_n != 2 || oe_n != 0 || ack_at != 2) begin
      errors++; $display("FAIL cpu_wr_strobes: got we=%0d oe=%0d ack_at=%0d, expected 2 0 2", we_n, oe_n, ack_at);
    end
  endtask

  task automatic test_download();
    int wr = 0;
    int last_rise = -1;
    int n_dl = 0;
    int n_other = 0;
    logic prev_we = 1'b0;
    @(negedge F14M);
    dl_active = 1; dl_req = 1; dl_addr = '0; dl_din = 8'h10;
    vid_req = 1; vid_addr = 25'h40; cpu_req = 1; cpu_addr = 25'h50; cpu_we = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_t'{2'd0, 8'h00});
    for (int c = 0; c < 60 && n_dl < 4; c++) begin
      @(negedge F14M);
      if (sd_we && !prev_we) begin
        checks++;
        if (sd_addr !== AW'(wr) || sd_din !== 8'(8'h10 + wr) || (wr > 0 && c - last_rise != 4)) begin
          errors++; $display("FAIL dl_write: got addr=%h din=%h gap=%0d, expected addr=%0d din=%h gap=4",
                             sd_addr, sd_din, c - last_rise, wr, 8'(8'h10 + wr));
        end
        last_rise = c; wr++;
      end
      prev_we = sd_we;
      if (vid_ack || cpu_ack) n_other++;
      if (dl_ack) begin
        n_dl++;
        if (n_dl == 4) begin
          dl_req = 0; vid_req = 0; cpu_req = 0; dl_active = 0;
        end else begin
          dl_addr = AW'(n_dl); dl_din = 8'(8'h10 + n_dl);
        end
      end
    end
    checks++;
    if (n_dl != 4 || wr != 4) begin errors++; $display("FAIL dl_count: got acks=%0d writes=%0d, expected 4 4", n_dl, wr); end
    checks++;
    if (n_other != 0) begin errors++; $display("FAIL dl_lockout: got %0d other acks, expected 0", n_other); end
  endtask

  task automatic test_round_robin();
    int n = 0;
    int nv = 0;
    int nc = 0;
    int last = -1;
    @(negedge F14M);
    RESET_n = 0; #2; RESET_n = 1;
    m_cpu = 8'h00;
    vid_addr = 25'h10; cpu_addr = 25'h20; cpu_we = 0; vid_req = 1; cpu_req = 1;
`ifdef VIDEO_PRIO_EN
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_t'{2'd1, 8'h4A});
`else
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(exp_t'{2'd1, 8'h4A});
      exp_q.push_back(exp_t'{2'd2, 8'h7A});
    end
`endif
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge F14M);
      if (vid_ack || cpu_ack) begin
        if (n > 0) begin
          checks++;
          if (c - last != 4) begin errors++; $display("FAIL rr_spacing: got %0d, expected 4", c - last); end
        end
        last = c;
        if (vid_ack) nv++;
        if (cpu_ack) nc++;
        n++;
        if (n == 4) begin vid_req = 0; cpu_req = 0; end
      end
    end
    m_cpu = 8'h7A;
    checks++;
`ifdef VIDEO_PRIO_EN
    if (nv != 4 || nc != 0) begin errors++; $display("FAIL prio_counts: got vid=%0d cpu=%0d, expected 4 0", nv, nc); end
`else
    if (nv != 2 || nc != 2) begin errors++; $display("FAIL rr_counts: got vid=%0d cpu=%0d, expected 2 2", nv, nc); end
`endif
  endtask

  task automatic test_reset_mid();
    int n_ack = 0;
    int ack_at = -1;
    @(negedge F14M);
    vid_addr = 25'h33; vid_req = 1;
    @(negedge F14M);
    @(negedge F14M);
    checks++;
    if (sd_oe !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got oe=%b, expected 1", sd_oe); end
    #1 RESET_n = 0;
    #1;
    checks++;
    if (sd_oe !== 1'b0 || busy !== 1'b0 || sd_addr !== '0 || vid_dout !== 8'h00 || cpu_dout !== 8'h00) begin
      errors++; $display("FAIL rst_mid_outs: got oe=%b busy=%b addr=%h vd=%h cd=%h, expected zeros",
                         sd_oe, busy, sd_addr, vid_dout, cpu_dout);
    end
    vid_req = 0; m_cpu = 8'h00;
    @(negedge F14M);
    RESET_n = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge F14M);
      if (dl_ack || vid_ack || cpu_ack) n_ack++;
    end
    checks++;
    if (n_ack != 0) begin errors++; $display("FAIL rst_mid_noack: got %0d acks, expected 0", n_ack); end
    cpu_addr = 25'h44; cpu_we = 0; cpu_req = 1;
    exp_q.push_back(exp_t'{2'd2, 8'h1E});
    for (int c = 0; c < 20 && ack_at < 0; c++) begin
      @(negedge F14M);
      if (cpu_ack) begin ack_at = c; cpu_req = 0; end
    end
    checks++;
    if (ack_at != 2) begin errors++; $display("FAIL rst_mid_regrant: got ack_at=%0d, expected 2", ack_at); end
  endtask

  task automatic test_slot5();
    int oe_n = 0;
    int ack_at = -1;
    @(negedge F14M);
    vid_addr5 = 25'h77; vid_req5 = 1;
    for (int c = 0; c < 30 && ack_at < 0; c++) begin
      @(negedge F14M);
      if (sd_oe5) oe_n++;
      if (vid_ack5) begin
        ack_at = c; vid_req5 = 0;
        checks++;
        if (vid_dout5 !== 8'h2D) begin errors++; $display("FAIL slot5_data: got %h, expected 2d", vid_dout5); end
      end
    end
    checks++;
    if (oe_n != 5 || ack_at != 5) begin
      errors++; $display("FAIL slot5_timing: got oe=%0d ack_at=%0d, expected 5 5", oe_n, ack_at);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_download();
    test_round_robin();
    test_reset_mid();
    test_slot5();
    repeat (3) @(negedge F14M);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
